// File: rtl/tcb_lib_pkg.sv
// Shared types and helpers for the TCB library blocks.
//   tcb_req_t / tcb_rsp_t : request and response payloads at the library's
//                           default bus widths.
//   arb_state_t           : arbiter grant FSM states.
//   rr_pick()             : round-robin search over a request vector.
package tcb_lib_pkg;

  localparam int unsigned TCB_ABW = 32;
  localparam int unsigned TCB_DBW = 32;
  localparam int unsigned TCB_SLW = 8;
  localparam int unsigned TCB_BEW = TCB_DBW / TCB_SLW;

  // Widest request vector rr_pick() can search (manager count limit).
  localparam int unsigned RR_MAX  = 16;

  typedef struct packed {
    logic               wen;
    logic [TCB_ABW-1:0] adr;
    logic [TCB_BEW-1:0] ben;
    logic [TCB_DBW-1:0] wdt;
  } tcb_req_t;

  typedef struct packed {
    logic [TCB_DBW-1:0] rdt;
    logic               err;
  } tcb_rsp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // First set bit of vld[n-1:0], searching upward from ptr and wrapping at n.
  // Returns 0 when nothing is set; callers qualify with their own "any".
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] vld,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned j;
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    j     = ptr;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        if (!found && (((vld >> j) & RR_MAX'(1)) != '0)) begin
          idx   = j;
          found = 1'b1;
        end
        j = ((j + 1) == n) ? 0 : j + 1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tcb_lib_arbiter_rr.sv
// Round-robin priority picker, purely combinational.
//   req : request vector, one bit per manager
//   ptr : index with highest priority this cycle
//   idx : winning index (0 when no request)
//   any : at least one request present
module tcb_lib_arbiter_rr
  import tcb_lib_pkg::*;
#(
  parameter int unsigned MPN = 2,
  parameter int unsigned IDW = $clog2(MPN)
) (
  input  logic [MPN-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           any
);

  assign idx = IDW'(rr_pick(RR_MAX'(req), 32'(ptr), MPN));
  assign any = |req;

endmodule

// File: rtl/tcb_lib_arbiter.sv
// Round-robin arbiter sharing one TCB subordinate among MPN managers.
//   clk, rst           : clock, asynchronous active-low reset
//   man_vld/wen/adr/ben/wdt : per-manager requests (packed by manager)
//   man_rdy/rdt/err    : per-manager handshake and routed response
//   sub_vld/wen/adr/ben/wdt : shared request toward the subordinate
//   sub_rdy/rdt/err    : subordinate handshake and response
// Requests pass through with zero latency. Once a grant meets back-pressure
// it is held until the handshake, so the subordinate sees a stable request.
// Responses arrive DLY cycles after the handshake and are steered by a
// {valid, index} shift register.
module tcb_lib_arbiter
  import tcb_lib_pkg::*;
#(
  parameter int unsigned MPN = 2,
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned BEW = DBW / SLW,
  parameter int unsigned DLY = 1,
  parameter int unsigned IDW = $clog2(MPN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MPN-1:0]           man_vld,
  input  logic [MPN-1:0]           man_wen,
  input  logic [MPN-1:0][ABW-1:0]  man_adr,
  input  logic [MPN-1:0][BEW-1:0]  man_ben,
  input  logic [MPN-1:0][DBW-1:0]  man_wdt,
  output logic [MPN-1:0]           man_rdy,
  output logic [MPN-1:0][DBW-1:0]  man_rdt,
  output logic [MPN-1:0]           man_err,
  output logic                     sub_vld,
  output logic                     sub_wen,
  output logic [ABW-1:0]           sub_adr,
  output logic [BEW-1:0]           sub_ben,
  output logic [DBW-1:0]           sub_wdt,
  input  logic                     sub_rdy,
  input  logic [DBW-1:0]           sub_rdt,
  input  logic                     sub_err
);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] ptr,   ptr_nxt;
  logic [IDW-1:0] held,  held_nxt;
  logic [IDW-1:0] rr_idx;
  logic           rr_any;
  logic [IDW-1:0] grant;
  logic           hs;

  function automatic logic [IDW-1:0] idx_inc(input logic [IDW-1:0] i);
    return (i == IDW'(MPN-1)) ? '0 : i + IDW'(1);
  endfunction

  tcb_lib_arbiter_rr #(.MPN(MPN), .IDW(IDW)) u_rr (
    .req (man_vld),
    .ptr (ptr),
    .idx (rr_idx),
    .any (rr_any)
  );

  assign grant = (state == ARB_HOLD) ? held : rr_idx;

  // Gated by rst so the shared port is quiet while reset is held.
  assign sub_vld = rst & ((state == ARB_HOLD) ? man_vld[held] : rr_any);
  assign hs      = sub_vld & sub_rdy;

  assign sub_wen = sub_vld & man_wen[grant];
  assign sub_adr = sub_vld ? man_adr[grant] : '0;
  assign sub_ben = sub_vld ? man_ben[grant] : '0;
  assign sub_wdt = sub_vld ? man_wdt[grant] : '0;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      held  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    held_nxt  = held;
    case (state)
      ARB_IDLE: begin
        if (sub_vld && !sub_rdy) begin
          state_nxt = ARB_HOLD;
          held_nxt  = grant;
        end else if (hs) begin
          ptr_nxt = idx_inc(grant);
        end
      end
      ARB_HOLD: begin
        // A held manager withdrawing is a protocol violation; release the
        // grant without advancing the pointer.
        if (!man_vld[held]) begin
          state_nxt = ARB_IDLE;
        end else if (sub_rdy) begin
          state_nxt = ARB_IDLE;
          ptr_nxt   = idx_inc(held);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // ------------------------------------------------------ response routing
  logic           tail_vld;
  logic [IDW-1:0] tail_idx;

  generate
    if (DLY == 0) begin : g_dly0
      assign tail_vld = hs;
      assign tail_idx = grant;
    end else begin : g_dlyn
      logic [DLY:1]          vld_pipe;
      logic [DLY:1][IDW-1:0] idx_pipe;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_pipe <= '0;
          idx_pipe <= '0;
        end else begin
          vld_pipe[1] <= hs;
          idx_pipe[1] <= grant;
          for (int s = 2; s <= int'(DLY); s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            idx_pipe[s] <= idx_pipe[s-1];
          end
        end
      end

      assign tail_vld = vld_pipe[DLY];
      assign tail_idx = idx_pipe[DLY];
    end
  endgenerate

  generate
    for (genvar i = 0; i < int'(MPN); i++) begin : g_man
      logic sel_rsp;
      assign sel_rsp    = tail_vld & (tail_idx == IDW'(i));
      assign man_rdy[i] = rst & sub_rdy & (grant == IDW'(i)) & man_vld[i];
      assign man_rdt[i] = sel_rsp ? sub_rdt : '0;
      assign man_err[i] = sel_rsp & sub_err;
    end
  endgenerate

  hold_keeps_vld_a: assert property (@(posedge clk) disable iff (!rst)
    (state == ARB_HOLD) |-> man_vld[held]);

endmodule
